// File: rtl/pc_sched_pkg.sv
// Shared MIPS pipeline definitions: boot/exception addresses, mult/div
// latencies and the mult/div busy state encoding.
package pc_sched_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
   localparam int unsigned MULT_CYC_DEF = 5;
   localparam int unsigned DIV_CYC_DEF  = 10;

   // Wide enough for any realistic mult/div latency
   localparam int unsigned MD_CNT_W = 8;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

endpackage : pc_sched_pkg

// File: rtl/pc_sched_md_busy_cnt.sv
// md_busy_cnt: mult/div busy countdown. A start accepted in RUN holds
// o_busy high for exactly MULT_CYC or DIV_CYC cycles; starts while busy
// are ignored. Asynchronous active-low reset aborts the countdown.
module md_busy_cnt
   import pc_sched_pkg::*;
#(
   parameter int unsigned MULT_CYC = MULT_CYC_DEF,
   parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   input  logic i_is_div,
   output logic o_busy
);

   md_state_e             r_state;
   md_state_e             w_state_nxt;
   logic [MD_CNT_W-1:0]   r_cnt;
   logic [MD_CNT_W-1:0]   w_cnt_nxt;

   // State and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Load on start in RUN, count down in MD_BUSY, leave on the last cycle
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         RUN: begin
            if (i_start) begin
               w_state_nxt = MD_BUSY;
               w_cnt_nxt   = i_is_div ? MD_CNT_W'(DIV_CYC) : MD_CNT_W'(MULT_CYC);
            end
         end
         MD_BUSY: begin
            w_cnt_nxt = r_cnt - 1'b1;
            if (r_cnt == MD_CNT_W'(1)) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = RUN;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign o_busy = (r_state == MD_BUSY);

endmodule : md_busy_cnt

// File: rtl/pc_sched.sv
// pc_sched: next-PC sequencer and stall scheduler for the 5-stage MIPS
// pipeline. Optional performance counters enabled by PC_SCHED_PERF_EN.
module pc_sched
   import pc_sched_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF,
   parameter int unsigned MULT_CYC = MULT_CYC_DEF,
   parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_f,
   input  logic        br_taken_d,
   input  logic [31:0] br_target_d,
   input  logic        j_d,
   input  logic [31:0] j_target_d,
   input  logic        jr_d,
   input  logic [31:0] jr_target_d,
   input  logic        load_use_hzd,
   input  logic        md_start_e,
   input  logic        md_is_div_e,
   input  logic        md_use_d,
   input  logic        exc_req,
   input  logic        eret_d,
   input  logic [31:0] epc,
   output logic [31:0] npc,
   output logic        pc_stall,
   output logic        fd_stall,
   output logic        fd_flush,
   output logic        de_flush,
   output logic        md_busy
`ifdef PC_SCHED_PERF_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events
`endif
);

   logic w_md_busy;
   logic w_md_hzd;
   logic w_stall;
   logic w_exc;

   md_busy_cnt #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC)
   ) u_md_busy_cnt (
      .clk      (clk),
      .rst      (rst),
      .i_start  (md_start_e),
      .i_is_div (md_is_div_e),
      .o_busy   (w_md_busy)
   );

   // Controls are forced low while reset is held
   assign w_exc    = exc_req & rst;
   assign w_md_hzd = md_use_d & (w_md_busy | md_start_e);
   assign w_stall  = (load_use_hzd | w_md_hzd) & ~exc_req & rst;

   assign pc_stall = w_stall;
   assign fd_stall = w_stall;
   assign fd_flush = w_exc;
   assign de_flush = w_stall | w_exc;
   assign md_busy  = w_md_busy;

   // Next-PC priority mux; redirects wait out a stall
   always_comb begin
      npc = pc_f + 32'd4;
      if (!rst)            npc = RESET_PC;
      else if (exc_req)    npc = EXC_VEC;
      else if (w_stall)    npc = pc_f;
      else if (eret_d)     npc = epc;
      else if (jr_d)       npc = jr_target_d;
      else if (j_d)        npc = j_target_d;
      else if (br_taken_d) npc = br_target_d;
   end

`ifdef PC_SCHED_PERF_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_events;

   // Saturating stall-cycle and exception-flush counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cycles <= '0;
         r_flush_events <= '0;
      end else begin
         if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
         if (w_exc && (r_flush_events != '1))   r_flush_events <= r_flush_events + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_events = r_flush_events;
`endif

endmodule : pc_sched

// File: tb/tb_pc_sched.sv
// Self-checking bench for pc_sched: directed scenarios plus randomized
// stimulus compared every cycle against a behavioural model.
// Build with PC_SCHED_PERF_EN defined to also cover the perf counters.
module tb_pc_sched;

   logic        clk;
   logic        rst;
   logic [31:0] pc_f;
   logic        br_taken_d;
   logic [31:0] br_target_d;
   logic        j_d;
   logic [31:0] j_target_d;
   logic        jr_d;
   logic [31:0] jr_target_d;
   logic        load_use_hzd;
   logic        md_start_e;
   logic        md_is_div_e;
   logic        md_use_d;
   logic        exc_req;
   logic        eret_d;
   logic [31:0] epc;
   logic [31:0] npc;
   logic        pc_stall;
   logic        fd_stall;
   logic        fd_flush;
   logic        de_flush;
   logic        md_busy;
`ifdef PC_SCHED_PERF_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_events;
`endif

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // Model: cycles of mult/div busy still remaining
   int unsigned busy_left = 0;
`ifdef PC_SCHED_PERF_EN
   logic [31:0] m_stall_cnt = '0;
   logic [31:0] m_flush_cnt = '0;
`endif

   pc_sched dut (
      .clk          (clk),
      .rst          (rst),
      .pc_f         (pc_f),
      .br_taken_d   (br_taken_d),
      .br_target_d  (br_target_d),
      .j_d          (j_d),
      .j_target_d   (j_target_d),
      .jr_d         (jr_d),
      .jr_target_d  (jr_target_d),
      .load_use_hzd (load_use_hzd),
      .md_start_e   (md_start_e),
      .md_is_div_e  (md_is_div_e),
      .md_use_d     (md_use_d),
      .exc_req      (exc_req),
      .eret_d       (eret_d),
      .epc          (epc),
      .npc          (npc),
      .pc_stall     (pc_stall),
      .fd_stall     (fd_stall),
      .fd_flush     (fd_flush),
      .de_flush     (de_flush),
      .md_busy      (md_busy)
`ifdef PC_SCHED_PERF_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_events (flush_events)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic m_stall();
      logic hzd;
      hzd = md_use_d && ((busy_left != 0) || md_start_e);
      return rst && (load_use_hzd || hzd) && !exc_req;
   endfunction

   function automatic logic [31:0] m_npc();
      if (!rst)                return 32'h0000_3000;
      if (exc_req)             return 32'h0000_4180;
      if (m_stall())           return pc_f;
      if (eret_d)              return epc;
      if (jr_d)                return jr_target_d;
      if (j_d)                 return j_target_d;
      if (br_taken_d)          return br_target_d;
      return pc_f + 32'd4;
   endfunction

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("npc",      npc,      m_npc());
         check("pc_stall", {31'b0, pc_stall}, {31'b0, m_stall()});
         check("fd_stall", {31'b0, fd_stall}, {31'b0, m_stall()});
         check("fd_flush", {31'b0, fd_flush}, {31'b0, rst && exc_req});
         check("de_flush", {31'b0, de_flush}, {31'b0, m_stall() || (rst && exc_req)});
         check("md_busy",  {31'b0, md_busy},  {31'b0, busy_left != 0});
`ifdef PC_SCHED_PERF_EN
         check("stall_cycles", stall_cycles, m_stall_cnt);
         check("flush_events", flush_events, m_flush_cnt);
`endif
      end
   end

   // Advance one clock edge, updating the model from the pre-edge inputs
   task automatic step();
      @(posedge clk);
      if (!rst) begin
         busy_left = 0;
      end else begin
`ifdef PC_SCHED_PERF_EN
         if (m_stall() && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt = m_stall_cnt + 1;
         if (exc_req && m_flush_cnt != 32'hFFFF_FFFF)   m_flush_cnt = m_flush_cnt + 1;
`endif
         if (busy_left != 0)  busy_left = busy_left - 1;
         else if (md_start_e) busy_left = md_is_div_e ? 10 : 5;
      end
      #1;
   endtask

   task automatic set_rst(input logic v);
      rst = v;
      if (!v) begin
         busy_left = 0;
`ifdef PC_SCHED_PERF_EN
         m_stall_cnt = '0;
         m_flush_cnt = '0;
`endif
      end
   endtask

   task automatic set_idle();
      br_taken_d = 0; j_d = 0; jr_d = 0; load_use_hzd = 0;
      md_start_e = 0; md_is_div_e = 0; md_use_d = 0;
      exc_req = 0; eret_d = 0;
   endtask

   int cnt;

   initial begin
      set_rst(1'b0);
      pc_f = 32'h0000_3000;
      br_target_d = 32'h0000_3100;
      j_target_d  = 32'h0000_3200;
      jr_target_d = 32'h0000_3300;
      epc         = 32'h0000_3400;
      set_idle();
      chk_en = 1'b1;

      // Reset state
      @(negedge clk);
      check("rst_npc", npc, 32'h0000_3000);
      check("rst_busy", {31'b0, md_busy}, 32'd0);
      step();
      set_rst(1'b1);
      @(negedge clk);
      check("boot_npc", npc, 32'h0000_3004);
      check("boot_flush", {30'b0, fd_flush, de_flush}, 32'd0);

      // Divide: busy/stall for exactly 10 cycles
      md_start_e = 1; md_is_div_e = 1;
      step();
      md_start_e = 0; md_use_d = 1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (md_busy && pc_stall) cnt++;
         step();
      end
      @(negedge clk);
      check("div_cycles", cnt, 32'd10);
      check("div_done_npc", npc, 32'h0000_3004);
      set_idle();

      // Load-use stall holds a taken branch until released
      pc_f = 32'h0000_3040; load_use_hzd = 1; br_taken_d = 1;
      @(negedge clk);
      check("lu_npc", npc, 32'h0000_3040);
      check("lu_deflush", {31'b0, de_flush}, 32'd1);
      step();
      load_use_hzd = 0;
      @(negedge clk);
      check("lu_release_npc", npc, 32'h0000_3100);
      step();
      set_idle();

      // Exception overrides stall and jr
      exc_req = 1; load_use_hzd = 1; jr_d = 1;
      @(negedge clk);
      check("exc_npc", npc, 32'h0000_4180);
      check("exc_flags", {29'b0, fd_flush, de_flush, pc_stall}, 32'b110);
      step();
      set_idle();

      // PC wrap
      pc_f = 32'hFFFF_FFFC;
      @(negedge clk);
      check("wrap_npc", npc, 32'h0000_0000);
      step();

      // Async reset aborts a multiply
      pc_f = 32'h0000_3000;
      md_start_e = 1; md_is_div_e = 0;
      step();
      md_start_e = 0;
      step();
      step();
      #2;
      set_rst(1'b0);
      #1;
      check("async_busy", {31'b0, md_busy}, 32'd0);
      check("async_npc", npc, 32'h0000_3000);
      step();
      set_rst(1'b1);
      @(negedge clk);
      check("post_rst_busy", {31'b0, md_busy}, 32'd0);
      check("post_rst_npc", npc, 32'h0000_3004);
      step();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         set_rst($urandom_range(0, 199) != 0);
         pc_f         = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         br_taken_d   = ($urandom_range(0, 3) == 0);
         br_target_d  = $urandom;
         j_d          = ($urandom_range(0, 7) == 0);
         j_target_d   = $urandom;
         jr_d         = ($urandom_range(0, 7) == 0);
         jr_target_d  = $urandom;
         eret_d       = ($urandom_range(0, 9) == 0);
         epc          = $urandom;
         load_use_hzd = ($urandom_range(0, 5) == 0);
         exc_req      = ($urandom_range(0, 15) == 0);
         md_start_e   = ($urandom_range(0, 7) == 0);
         md_is_div_e  = $urandom_range(0, 1);
         md_use_d     = ($urandom_range(0, 2) == 0);
         step();
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_pc_sched
